// File: rtl/counter_pkg.sv
// Shared definitions for the debounced up/down counter: data width, default bound
// and the button debounce state encoding.
package counter_pkg;

    localparam int DATA_W        = 5;
    localparam int MAX_VALUE_DEF = 31;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

endpackage

// File: rtl/btn_debouncer.sv
// Synchronizes and debounces one active-low button, then emits a one-cycle press pulse.
// Latency: the pulse appears DEBOUNCE_CYCLES+2 edges after the first low sample. Releases are silent.
module btn_debouncer
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // The sample that leaves a stable state counts as the first one, so the
    // counter only needs to reach DEBOUNCE_CYCLES-2 inside the wait states.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

    logic             sync1_q, sync2_q;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;
    logic             press_q, press_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RELEASED;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= i_btn_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            RELEASED: begin
                if (!sync2_q) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (sync2_q) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (sync2_q) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (!sync2_q) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    // Pulse on the rising edge of the "held" level; bouncing back from
    // RELEASE_WAIT to PRESSED keeps the level high and so cannot re-trigger.
    always_comb begin
        lvl_d   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
        press_d = lvl_d && !lvl_q;
    end

    assign o_press = press_q;

endmodule

// File: rtl/updown_counter.sv
// Debounced up/down counter driving the HEX decoder; clear has priority over presses.
// Build option COUNTER_WRAP_EN: wrap at the bounds instead of saturating.
module updown_counter
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int MAX_VALUE       = MAX_VALUE_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_btn_up_n,
    input  logic              i_btn_down_n,
    input  logic              i_clear,
    output logic [DATA_W-1:0] o_data,
    output logic              o_changed
);

    localparam logic [DATA_W:0]   MAX_EXT = (DATA_W + 1)'(MAX_VALUE);
    localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(MAX_VALUE);

    logic              up_pulse, dn_pulse;
    logic [DATA_W-1:0] data_q, data_d;
    logic              changed_q, changed_d;
    logic [DATA_W:0]   data_ext, inc_ext, dec_ext;

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn_n (i_btn_up_n),
        .o_press (up_pulse)
    );

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn_n (i_btn_down_n),
        .o_press (dn_pulse)
    );

    // One extra bit of headroom: an increment past MAX_VALUE or a decrement
    // below zero both land above MAX_EXT and are caught before truncation.
    always_comb begin
        data_ext = {1'b0, data_q};
        inc_ext  = data_ext + (DATA_W + 1)'(1);
        dec_ext  = data_ext - (DATA_W + 1)'(1);
        data_d   = data_q;
        if (i_clear) begin
            data_d = '0;
        end else if (up_pulse && dn_pulse) begin
            data_d = data_q;
        end else if (up_pulse) begin
`ifdef COUNTER_WRAP_EN
            data_d = (inc_ext > MAX_EXT) ? '0 : inc_ext[DATA_W-1:0];
`else
            data_d = (inc_ext > MAX_EXT) ? data_q : inc_ext[DATA_W-1:0];
`endif
        end else if (dn_pulse) begin
`ifdef COUNTER_WRAP_EN
            data_d = (dec_ext > MAX_EXT) ? MAX_VAL : dec_ext[DATA_W-1:0];
`else
            data_d = (dec_ext > MAX_EXT) ? data_q : dec_ext[DATA_W-1:0];
`endif
        end
        changed_d = (data_d != data_q);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            data_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            changed_q <= changed_d;
        end
    end

    assign o_data    = data_q;
    assign o_changed = changed_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter with DEBOUNCE_CYCLES=4; expectations follow the
// build option COUNTER_WRAP_EN.
module tb_updown_counter;

`ifdef COUNTER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_up_n;
    logic       btn_dn_n;
    logic       clear;
    logic [4:0] data;
    logic       changed;

    int tests  = 0;
    int fails  = 0;
    int chg_cnt = 0;

    updown_counter #(.DEBOUNCE_CYCLES(4), .MAX_VALUE(31)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_btn_up_n   (btn_up_n),
        .i_btn_down_n (btn_dn_n),
        .i_clear      (clear),
        .o_data       (data),
        .o_changed    (changed)
    );

    always #5 clk = ~clk;

    // Advance n edges; inputs change and outputs are sampled 1 time unit after each edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chg_cnt += int'(changed);
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input bit up, input bit dn);
        btn_up_n = ~up;
        btn_dn_n = ~dn;
        run(10);
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        run(10);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        run(1);
        clear = 1'b0;
        run(1);
    endtask

    initial begin
        int bad;
        rst_n    = 1'b0;
        btn_up_n = 1'b1;
        btn_dn_n = 1'b1;
        clear    = 1'b0;
        run(3);
        check("reset_data", int'(data), 0);
        check("reset_changed", int'(changed), 0);
        rst_n = 1'b1;

        // Idle after reset
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            run(1);
            if (data !== 5'd0 || changed !== 1'b0) bad++;
        end
        check("idle_20_cycles", bad, 0);

        // 3-cycle glitch is rejected
        chg_cnt = 0;
        btn_up_n = 1'b0;
        run(3);
        btn_up_n = 1'b1;
        run(20);
        check("glitch_data", int'(data), 0);
        check("glitch_changed", chg_cnt, 0);

        // Clean press held 30 cycles: update on the 7th edge after the first low sample
        chg_cnt = 0;
        btn_up_n = 1'b0;
        run(7);
        check("press_before_latency", int'(data), 0);
        run(1);
        check("press_at_latency", int'(data), 1);
        check("press_changed_pulse", int'(changed), 1);
        run(1);
        check("press_changed_one_cycle", int'(changed), 0);
        run(21);
        btn_up_n = 1'b1;
        run(15);
        check("press_held_release_data", int'(data), 1);
        check("press_single_pulse", chg_cnt, 1);

        // Clear from 1
        clear = 1'b1;
        run(1);
        clear = 1'b0;
        check("clear_data", int'(data), 0);
        check("clear_changed", int'(changed), 1);
        run(1);

        // Down at zero
        chg_cnt = 0;
        press(1'b0, 1'b1);
        check("down_at_zero_data", int'(data), WRAP ? 31 : 0);
        check("down_at_zero_changed", chg_cnt, WRAP ? 1 : 0);

        // 32 up presses from zero
        do_clear();
        check("clear_before_ups", int'(data), 0);
        for (int i = 0; i < 31; i++) press(1'b1, 1'b0);
        check("up31_data", int'(data), 31);
        chg_cnt = 0;
        press(1'b1, 1'b0);
        check("up32_data", int'(data), WRAP ? 0 : 31);
        check("up32_changed", chg_cnt, WRAP ? 1 : 0);

        // Up and down on the same edge
        chg_cnt = 0;
        press(1'b1, 1'b1);
        check("both_data", int'(data), WRAP ? 0 : 31);
        check("both_changed", chg_cnt, 0);

        // Clear coincident with an up pulse at 5
        do_clear();
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
        check("reach_5", int'(data), 5);
        btn_up_n = 1'b0;
        run(7);
        check("clear_vs_up_before", int'(data), 5);
        clear = 1'b1;
        run(1);
        clear = 1'b0;
        check("clear_vs_up_data", int'(data), 0);
        check("clear_vs_up_changed", int'(changed), 1);
        run(5);
        check("clear_vs_up_after", int'(data), 0);
        btn_up_n = 1'b1;
        run(10);

        // Reset mid PRESS_WAIT at 12, button held through reset
        for (int i = 0; i < 12; i++) press(1'b1, 1'b0);
        check("reach_12", int'(data), 12);
        btn_up_n = 1'b0;
        run(4);
        rst_n = 1'b0;
        #1;
        check("async_reset_data", int'(data), 0);
        check("async_reset_changed", int'(changed), 0);
        run(2);
        rst_n = 1'b1;
        run(7);
        check("held_after_reset_before", int'(data), 0);
        run(1);
        check("held_after_reset_data", int'(data), 1);
        check("held_after_reset_changed", int'(changed), 1);
        btn_up_n = 1'b1;
        run(10);
        check("held_after_reset_final", int'(data), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
